// File: rtl/instr_fetch_stage.sv
// PC register and IF/ID pipeline register with branch/jump redirect and stall handling.
// Define FETCH_DELAY_SLOT_EN to keep the delay-slot instruction on a redirect instead of squashing it.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             stall,
    input  logic             jump_en,
    input  logic [25:0]      jump_index,
    input  logic             branch_en,
    input  logic [31:0]      branch_target,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] jump_tgt;
    logic [31:0] branch_tgt;
    logic        redirect;

    assign pc_plus4   = pc_q + 32'd4;
    assign jump_tgt   = {pc4_q[31:28], jump_index, 2'b00};
    assign branch_tgt = {branch_target[31:2], 2'b00};
    assign redirect   = branch_en | jump_en;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        mis_d   = branch_en & (branch_target[1:0] != 2'b00);

        // The older instruction (branch in EX) wins over a jump in ID.
        if (branch_en) begin
            pc_d = branch_tgt;
        end else if (jump_en) begin
            pc_d = jump_tgt;
        end else if (!stall) begin
            pc_d = pc_plus4;
        end

        if (redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
            instr_d = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
`else
            instr_d = NOP_WORD;
            pc4_d   = pc_plus4;
            valid_d = 1'b0;
`endif
        end else if (!stall) begin
            instr_d = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr    = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc4    = pc4_q;
    assign if_id_valid  = valid_q;
    assign misalign_err = mis_q;
    assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: directed cycles push expected state, a monitor pops and compares.
module tb_instr_fetch_stage;

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_data;
    logic        stall, jump_en, branch_en;
    logic [25:0] jump_index;
    logic [31:0] branch_target;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid, misalign_err;
    logic [15:0] fetch_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   done  = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'h8C02_0004;
            32'h0000_0004: rom = 32'h0042_1020;
            32'h0000_0008: rom = 32'h0800_0007;
            32'h0000_000C: rom = 32'h2003_000C;
            32'h0000_0010: rom = 32'h1111_1111;
            32'h0000_0014: rom = 32'h2222_2222;
            32'h0000_001C: rom = 32'h3333_3333;
            32'h0000_0020: rom = 32'h4444_4444;
            32'h0000_0040: rom = 32'h5555_5555;
            32'h0000_0044: rom = 32'h6666_6666;
            32'hFFFF_FFFC: rom = 32'h7777_7777;
            default:       rom = 32'hFFFF_FFFF;
        endcase
    endfunction

    assign imem_data = rom(imem_addr);

    instr_fetch_stage dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .jump_en(jump_en), .jump_index(jump_index),
        .branch_en(branch_en), .branch_target(branch_target),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // Monitor: compares the registered state once per cycle, away from the rising edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("imem_addr",    imem_addr, e.pc);
            chk("if_id_instr",  if_id_instr, e.instr);
            chk("if_id_pc4",    if_id_pc4, e.pc4);
            chk("if_id_valid",  {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
            chk("fetch_count",  {16'd0, fetch_count}, {16'd0, e.cnt});
        end
    end

    task automatic cyc(input logic rst, input logic st, input logic je, input logic [25:0] ji,
                       input logic be, input logic [31:0] bt, input exp_t e);
        reset = rst; stall = st; jump_en = je; jump_index = ji;
        branch_en = be; branch_target = bt;
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    task automatic norm(input exp_t e);
        cyc(1'b0, 1'b0, 1'b0, 26'd0, 1'b0, 32'd0, e);
    endtask

    // Expected IF/ID after a redirect edge: delay slot kept or squashed.
    function automatic exp_t redir(input logic [31:0] npc, input logic [31:0] word,
                                   input logic [31:0] pc4, input logic mis, input logic [15:0] cnt_before);
        exp_t e;
        e.pc    = npc;
        e.instr = DS ? word : NOP;
        e.pc4   = pc4;
        e.valid = DS;
        e.mis   = mis;
        e.cnt   = cnt_before + {15'd0, DS};
        return e;
    endfunction

    initial begin
        logic [15:0] c;
        exp_t rst_e;
        rst_e = '{pc: 32'h0, instr: NOP, pc4: 32'h0, valid: 1'b0, mis: 1'b0, cnt: 16'd0};

        cyc(1'b1, 1'b0, 1'b0, 26'd0, 1'b0, 32'd0, rst_e);
        cyc(1'b1, 1'b0, 1'b0, 26'd0, 1'b0, 32'd0, rst_e);

        // Sequential fetch of lw / add / j
        norm('{pc: 32'h4, instr: 32'h8C02_0004, pc4: 32'h4, valid: 1'b1, mis: 1'b0, cnt: 16'd1});
        norm('{pc: 32'h8, instr: 32'h0042_1020, pc4: 32'h8, valid: 1'b1, mis: 1'b0, cnt: 16'd2});
        norm('{pc: 32'hC, instr: 32'h0800_0007, pc4: 32'hC, valid: 1'b1, mis: 1'b0, cnt: 16'd3});
        c = 16'd3;

        // Jump index 7 with if_id_pc4 = 0xC -> 0x1C
        cyc(1'b0, 1'b0, 1'b1, 26'd7, 1'b0, 32'd0, redir(32'h1C, 32'h2003_000C, 32'h10, 1'b0, c));
        c = c + DS;
        c = c + 1;
        norm('{pc: 32'h20, instr: 32'h3333_3333, pc4: 32'h20, valid: 1'b1, mis: 1'b0, cnt: c});

        // Branch beats simultaneous jump and stall
        cyc(1'b0, 1'b1, 1'b1, 26'h3FF_FFFF, 1'b1, 32'h40, redir(32'h40, 32'h4444_4444, 32'h24, 1'b0, c));
        c = c + DS;
        c = c + 1;
        norm('{pc: 32'h44, instr: 32'h5555_5555, pc4: 32'h44, valid: 1'b1, mis: 1'b0, cnt: c});

        // Misaligned branch target 0x42 -> 0x40, one-cycle error pulse
        cyc(1'b0, 1'b0, 1'b0, 26'd0, 1'b1, 32'h42, redir(32'h40, 32'h6666_6666, 32'h48, 1'b1, c));
        c = c + DS;
        c = c + 1;
        norm('{pc: 32'h44, instr: 32'h5555_5555, pc4: 32'h44, valid: 1'b1, mis: 1'b0, cnt: c});

        // Move to 0x10, then stall three cycles
        cyc(1'b0, 1'b0, 1'b0, 26'd0, 1'b1, 32'h10, redir(32'h10, 32'h6666_6666, 32'h48, 1'b0, c));
        c = c + DS;
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 1'b0, 26'd0, 1'b0, 32'd0, redir(32'h10, 32'h6666_6666, 32'h48, 1'b0, c - {15'd0, DS}));
        c = c + 1;
        norm('{pc: 32'h14, instr: 32'h1111_1111, pc4: 32'h14, valid: 1'b1, mis: 1'b0, cnt: c});

        // PC wrap at the top of the address space
        cyc(1'b0, 1'b0, 1'b0, 26'd0, 1'b1, 32'hFFFF_FFFC, redir(32'hFFFF_FFFC, 32'h2222_2222, 32'h18, 1'b0, c));
        c = c + DS;
        c = c + 1;
        norm('{pc: 32'h0, instr: 32'h7777_7777, pc4: 32'h0, valid: 1'b1, mis: 1'b0, cnt: c});

        // Reset during a misaligned branch with stall discards everything
        cyc(1'b1, 1'b1, 1'b1, 26'd5, 1'b1, 32'h42, rst_e);
        norm('{pc: 32'h4, instr: 32'h8C02_0004, pc4: 32'h4, valid: 1'b1, mis: 1'b0, cnt: 16'd1});

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        done = 1'b1;
    end

    initial begin
        fork
            wait (done);
            begin
                #100000;
                tests++;
                fails++;
                $display("FAIL timeout: bench did not complete, expected completion");
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
